uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter OVERSAMPLE, default 16: tick pulses per bit; legal values are even and at least 8.
REQ-002 Parameter FIFO_DEPTH, default 8: number of receive FIFO entries; legal values are powers of 2 and at least 2.
REQ-003 Parameter CTS_MARGIN, default 2: free FIFO entries remaining when cts_n deasserts; legal range is 1 to FIFO_DEPTH-1.
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 tick  in  1  one-clk pulse at OVERSAMPLE x baud.
REQ-007 rx  in  1  serial line, idle high, asynchronous to clk.
REQ-008 data_bit_num  in  2  data bits per frame: 00=5, 01=6, 10=7, 11=8.
REQ-009 stop_bit_num  in  1  stop bits per frame: 0=1, 1=2.
REQ-010 parity_en  in  1  1 = frame carries a parity bit.
REQ-011 parity_type  in  1  0=even, 1=odd.
REQ-012 rx_ready  in  1  consumer accepts the FIFO head entry.
REQ-013 overrun_clr  in  1  one-clk pulse that clears the overrun flag.
REQ-014 rx_valid  out  1  FIFO not empty.
REQ-015 rx_data  out  8  head entry data, LSB = first received bit, unused upper bits 0.
REQ-016 rx_parity_err, rx_frame_err, rx_break  out  1 each  head entry status flags.
REQ-017 rx_count  out  $clog2(FIFO_DEPTH+1)  number of FIFO entries.
REQ-018 overrun  out  1  sticky flag: a frame was dropped because the FIFO was full.
REQ-019 cts_n  out  1  flow control, 0 = peer may send.

Function
REQ-020 rx SHALL pass through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-021 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, PUSH; only tick-qualified cycles advance the tick counter.
REQ-022 IDLE SHALL arm once rx is sampled high on a tick, and SHALL enter START on the first tick with rx low while armed; tick counter is cleared on entry.
REQ-023 START: at tick count OVERSAMPLE/2-1, rx=1 SHALL return to IDLE (false start, nothing pushed); rx=0 SHALL enter DATA with the tick counter cleared.
REQ-024 At START->DATA, data_bit_num, stop_bit_num, parity_en and parity_type SHALL be latched; changes mid-frame do not affect the current frame.
REQ-025 Each bit SHALL be decided at tick count OVERSAMPLE-1, then the tick counter wraps to 0.
REQ-026 DATA SHALL shift in the latched number of bits LSB-first, then go to PARITY if parity is enabled, otherwise to STOP.
REQ-027 Parity error SHALL be flagged when (XOR of data bits XOR parity bit) differs from parity_type.
REQ-028 STOP: a stop bit decided 0 SHALL set frame_err and go directly to PUSH, with the FSM disarmed; otherwise PUSH follows the last stop bit.
REQ-029 Break SHALL be flagged when all data bits, the parity bit (if enabled) and the first stop bit are 0; break implies frame_err=1.
REQ-030 PUSH SHALL last one clk and write {break, frame_err, parity_err, data} to the FIFO, then go to IDLE.
REQ-031 rx_valid SHALL rise the clk after PUSH; rx_data and the flags are driven combinationally from the head entry.
REQ-032 A pop SHALL occur on rx_valid && rx_ready; rx_ready while empty SHALL have no effect.
REQ-033 A push while full SHALL drop the frame and set overrun, unless a pop occurs in the same cycle, in which case the push is accepted and rx_count is unchanged.
REQ-034 Simultaneous push and pop while not full SHALL leave rx_count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-035 When overrun_clr coincides with a new overrun, set SHALL win.
REQ-036 cts_n SHALL be a registered output equal to (rx_count >= FIFO_DEPTH-CTS_MARGIN), updated the clk after the count changes.

Reset
REQ-037 While rst_n is low: FSM=IDLE and disarmed, synchronizer flops=1, FIFO empty, rx_valid=0, rx_count=0, rx_data=0, all flags=0, overrun=0, cts_n=0.
REQ-038 Reset mid-frame SHALL discard the partial frame; the FSM re-arms only after rx is sampled high.

Configuration
REQ-039 With UART_RX_MAJORITY_EN defined, each bit SHALL be the 2-of-3 majority of samples at tick counts OVERSAMPLE-3, OVERSAMPLE-2 and OVERSAMPLE-1; without it, the single sample at OVERSAMPLE-1 SHALL be used, and the START false-start check is unaffected either way.

Verification
REQ-040 8N1, 0xA5, OVERSAMPLE=16 -> one entry: rx_data=0xA5, all flags 0, rx_valid high the clk after PUSH.
REQ-041 5O2, 0x13 with correct parity, then 0x13 with the parity bit inverted -> entries 0x13/perr=0 and 0x13/perr=1.
REQ-042 Line held low for 2 frame times -> one entry: data=0x00, break=1, frame_err=1; no new frame until rx returns high.
REQ-043 FIFO_DEPTH=4, 5 frames, no pops -> 4 entries, overrun=1, cts_n=1 once count=2; a pop plus a push on the same cycle while full -> accepted, overrun unchanged.
REQ-044 rx low glitch of 4 ticks -> returns to IDLE, nothing pushed; with UART_RX_MAJORITY_EN, a 1-tick glitch at a data bit center -> data unchanged.
REQ-045 rst_n asserted during bit 3 of a frame -> all outputs at reset values; the next clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with 2-flop rx sync, oversampled framing FSM and status-tagged receive FIFO; entry visible the clk after PUSH.
// A full FIFO drops the frame and sets overrun unless a same-cycle pop frees a slot; cts_n asks the peer to pause. Option: UART_RX_MAJORITY_EN.
module uart_rx_fifo #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CTS_MARGIN = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            tick,
  input  logic                            rx,
  input  logic [1:0]                      data_bit_num,
  input  logic                            stop_bit_num,
  input  logic                            parity_en,
  input  logic                            parity_type,
  input  logic                            rx_ready,
  input  logic                            overrun_clr,
  output logic                            rx_valid,
  output logic [7:0]                      rx_data,
  output logic                            rx_parity_err,
  output logic                            rx_frame_err,
  output logic                            rx_break,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
  output logic                            overrun,
  output logic                            cts_n
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, PUSH} state_t;

  state_t          state;
  logic [TW-1:0]   cnt;
  logic            armed;
  logic [2:0]      bit_idx;
  logic [1:0]      dbits_l;
  logic            two_stop, par_en_l, par_type_l;
  logic [7:0]      shreg;
  logic            par_acc, zero_acc, perr, ferr, brk, stop_idx;
  logic            rx_s1, rx_s2;
  logic            bit_val, bit_done, push;
  logic [2:0]      last_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic smp_a, smp_b;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_a <= 1'b1;
      smp_b <= 1'b1;
    end else if (tick) begin
      if (cnt == TW'(OVERSAMPLE - 3)) smp_a <= rx_s2;
      if (cnt == TW'(OVERSAMPLE - 2)) smp_b <= rx_s2;
    end
  end
  assign bit_val = (smp_a & smp_b) | (smp_a & rx_s2) | (smp_b & rx_s2);
`else
  assign bit_val = rx_s2;
`endif

  assign bit_done = tick && (cnt == T_LAST);
  assign last_idx = 3'd4 + {1'b0, dbits_l};
  assign push     = (state == PUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE; cnt <= '0; armed <= 1'b0; bit_idx <= '0;
      dbits_l <= '0; two_stop <= 1'b0; par_en_l <= 1'b0; par_type_l <= 1'b0;
      shreg <= '0; par_acc <= 1'b0; zero_acc <= 1'b0;
      perr <= 1'b0; ferr <= 1'b0; brk <= 1'b0; stop_idx <= 1'b0;
    end else begin
      if (tick && (state == DATA || state == PARITY || state == STOP))
        cnt <= (cnt == T_LAST) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (tick) begin
          if (rx_s2) armed <= 1'b1;
          else if (armed) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: if (tick) begin
          if (cnt == T_HALF) begin
            if (rx_s2) state <= IDLE;
            else begin
              state <= DATA; cnt <= '0; bit_idx <= '0;
              dbits_l <= data_bit_num; two_stop <= stop_bit_num;
              par_en_l <= parity_en; par_type_l <= parity_type;
              shreg <= '0; par_acc <= 1'b0; zero_acc <= 1'b1;
              perr <= 1'b0; ferr <= 1'b0; brk <= 1'b0; stop_idx <= 1'b0;
            end
          end else cnt <= cnt + 1'b1;
        end
        DATA: if (bit_done) begin
          shreg[bit_idx] <= bit_val;
          par_acc  <= par_acc ^ bit_val;
          zero_acc <= zero_acc & ~bit_val;
          if (bit_idx == last_idx) state <= par_en_l ? PARITY : STOP;
          else bit_idx <= bit_idx + 3'd1;
        end
        PARITY: if (bit_done) begin
          perr     <= (par_acc ^ bit_val) != par_type_l;
          zero_acc <= zero_acc & ~bit_val;
          state    <= STOP;
        end
        STOP: if (bit_done) begin
          // a low stop bit ends the frame at once; wait for idle-high before re-arming
          if (!bit_val) begin
            ferr  <= 1'b1;
            brk   <= zero_acc && !stop_idx;
            armed <= 1'b0;
            state <= PUSH;
          end else if (stop_idx == two_stop) state <= PUSH;
          else stop_idx <= 1'b1;
        end
        PUSH:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [10:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, wr_en;
  logic [10:0]   head;

  assign full  = (rx_count == CW'(FIFO_DEPTH));
  assign pop   = rx_valid && rx_ready;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {brk, ferr, perr, shreg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0; rd_ptr <= '0; rx_count <= '0;
      overrun <= 1'b0; cts_n <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
      if (push && full && !pop) overrun <= 1'b1;
      else if (overrun_clr)     overrun <= 1'b0;
      cts_n <= (rx_count >= CW'(FIFO_DEPTH - CTS_MARGIN));
    end
  end

  // storage is not reset, so the head is masked until an entry exists
  assign rx_valid      = (rx_count != '0);
  assign head          = rx_valid ? mem[rd_ptr] : 11'd0;
  assign rx_data       = head[7:0];
  assign rx_parity_err = head[8];
  assign rx_frame_err  = head[9];
  assign rx_break      = head[10];
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: FIFO_DEPTH=4, OVERSAMPLE=16, tick every 4 clk.
module tb_uart_rx_fifo;
  logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0, rx = 1'b1;
  logic [1:0] data_bit_num = 2'b11;
  logic       stop_bit_num = 1'b0, parity_en = 1'b0, parity_type = 1'b0;
  logic       rx_ready = 1'b0, overrun_clr = 1'b0;
  logic       rx_valid, rx_parity_err, rx_frame_err, rx_break, overrun, cts_n;
  logic [7:0] rx_data;
  logic [2:0] rx_count;
  int         checks = 0, failures = 0, tdiv = 0;
  bit         ok;

  uart_rx_fifo #(.OVERSAMPLE(16), .FIFO_DEPTH(4), .CTS_MARGIN(2)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx),
    .data_bit_num(data_bit_num), .stop_bit_num(stop_bit_num),
    .parity_en(parity_en), .parity_type(parity_type),
    .rx_ready(rx_ready), .overrun_clr(overrun_clr),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .rx_break(rx_break), .rx_count(rx_count),
    .overrun(overrun), .cts_n(cts_n)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      tick = (tdiv == 3);
      tdiv = (tdiv + 1) % 4;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!tick) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_ticks(16);
  endtask

  task automatic send_data(input logic [7:0] d, input int nb, input int glitch_bit);
    for (int i = 0; i < nb; i++) begin
      if (i == glitch_bit) begin
        rx = d[i];  wait_ticks(7);
        rx = ~d[i]; wait_ticks(1);
        rx = d[i];  wait_ticks(8);
      end else send_bit(d[i]);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit ptype,
                            input int ns, input bit pflip, input int glitch_bit);
    logic p;
    p = ptype ^ pflip;
    for (int i = 0; i < nb; i++) p = p ^ d[i];
    send_bit(1'b0);
    send_data(d, nb, glitch_bit);
    if (pen) send_bit(p);
    for (int i = 0; i < ns; i++) send_bit(1'b1);
    wait_ticks(4);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_push(output bit found);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (dut.push === 1'b1) found = 1'b1;
    end
  endtask

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_count", 32'(rx_count), 0);
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_flags", 32'({rx_break, rx_frame_err, rx_parity_err}), 0);
    chk("rst_ovr_cts", 32'({overrun, cts_n}), 0);
    rst_n = 1'b1;
    wait_ticks(32);

    // 8N1 0xA5, with rx_valid timing relative to PUSH
    send_bit(1'b0);
    send_data(8'hA5, 8, -1);
    rx = 1'b1;
    wait_push(ok);
    chk("a5_push_seen", 32'(ok), 1);
    chk("a5_valid_in_push", 32'(rx_valid), 0);
    @(negedge clk);
    chk("a5_valid_after_push", 32'(rx_valid), 1);
    wait_ticks(16);
    chk("a5_data", 32'(rx_data), 32'hA5);
    chk("a5_flags", 32'({rx_break, rx_frame_err, rx_parity_err}), 0);
    chk("a5_count", 32'(rx_count), 1);
    pop_one();
    chk("a5_pop_count", 32'(rx_count), 0);
    chk("a5_pop_valid", 32'(rx_valid), 0);

    // 5O2 0x13 good parity, then flipped parity
    data_bit_num = 2'b00; stop_bit_num = 1'b1; parity_en = 1'b1; parity_type = 1'b1;
    send_frame(8'h13, 5, 1'b1, 1'b1, 2, 1'b0, -1);
    send_frame(8'h13, 5, 1'b1, 1'b1, 2, 1'b1, -1);
    chk("5o2_count", 32'(rx_count), 2);
    chk("5o2_cts", 32'(cts_n), 1);
    chk("5o2_d0", 32'(rx_data), 32'h13);
    chk("5o2_perr0", 32'({rx_break, rx_frame_err, rx_parity_err}), 0);
    pop_one();
    chk("5o2_d1", 32'(rx_data), 32'h13);
    chk("5o2_perr1", 32'({rx_break, rx_frame_err, rx_parity_err}), 3'b001);
    pop_one();
    chk("5o2_empty", 32'(rx_count), 0);

    // break: line low for two 8N1 frame times
    data_bit_num = 2'b11; stop_bit_num = 1'b0; parity_en = 1'b0; parity_type = 1'b0;
    rx = 1'b0;
    wait_ticks(320);
    chk("brk_count", 32'(rx_count), 1);
    chk("brk_data", 32'(rx_data), 0);
    chk("brk_flags", 32'({rx_break, rx_frame_err, rx_parity_err}), 3'b110);
    rx = 1'b1;
    wait_ticks(40);
    chk("brk_no_new", 32'(rx_count), 1);
    pop_one();

    // 4-tick low glitch is a false start
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(40);
    chk("glitch_count", 32'(rx_count), 0);

    // fill a 4-deep FIFO with 5 frames, no pops
    for (int f = 1; f <= 5; f++) begin
      send_frame(8'(f), 8, 1'b0, 1'b0, 1, 1'b0, -1);
      if (f == 1) chk("ovf_cts_at1", 32'(cts_n), 0);
      if (f == 2) chk("ovf_cts_at2", 32'(cts_n), 1);
      if (f == 4) chk("ovf_none_at4", 32'(overrun), 0);
    end
    chk("ovf_count", 32'(rx_count), 4);
    chk("ovf_flag", 32'(overrun), 1);
    chk("ovf_head", 32'(rx_data), 32'h01);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("ovf_clr", 32'(overrun), 0);

    // pop coinciding with push while full
    send_bit(1'b0);
    send_data(8'h06, 8, -1);
    rx = 1'b1;
    wait_push(ok);
    chk("pp_push_seen", 32'(ok), 1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("pp_count", 32'(rx_count), 4);
    chk("pp_overrun", 32'(overrun), 0);
    chk("pp_head", 32'(rx_data), 32'h02);
    wait_ticks(16);
    pop_one(); pop_one();
    chk("pp_d4", 32'(rx_data), 32'h04);
    pop_one();
    chk("pp_d6", 32'(rx_data), 32'h06);
    chk("pp_count1", 32'(rx_count), 1);

`ifdef UART_RX_MAJORITY_EN
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b0, 2);
    chk("maj_count", 32'(rx_count), 2);
    pop_one();
    chk("maj_data", 32'(rx_data), 32'h3C);
`endif

    // reset during bit 3 of 0x5A
    send_bit(1'b0);
    send_data(8'h5A, 3, -1);
    rx = 1'b1;
    wait_ticks(8);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_valid", 32'(rx_valid), 0);
    chk("mrst_count", 32'(rx_count), 0);
    chk("mrst_data", 32'(rx_data), 0);
    chk("mrst_misc", 32'({rx_break, rx_frame_err, rx_parity_err, overrun, cts_n}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(32);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b0, -1);
    chk("mrst_count_after", 32'(rx_count), 1);
    chk("mrst_data_after", 32'(rx_data), 32'h5A);
    chk("mrst_flags_after", 32'({rx_break, rx_frame_err, rx_parity_err}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
